// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//
// Control unit for the bus computer. It owns the instruction register (IR) and
// the micro-step counter, and decodes opcode + step into the control word that
// drives the datapath.
//
// Timing: the step counter advances on the falling clock edge, so the control
// word is settled across every rising edge, which is where the datapath and
// the IR latch.
//
// Parameters
//   BUS_SIZE  width of the bus and the IR
//   ADR_SIZE  width of the operand field IR[ADR_SIZE-1:0]
//   STEPS     micro-steps per instruction (5..8, the step port is 3 bits)
//
// Ports
//   clk     in   system clock
//   clr     in   asynchronous active-high reset; forces all controls to 0
//   bus     in   shared bus, loaded into the IR when ii=1
//   cf, zf  in   registered carry / zero flags from the datapath
//   ir_out  out  {zeros, IR operand field}, driven onto the bus when io=1
//   step    out  current micro-step
//   hlt .. fi    out  active-high control word
// -----------------------------------------------------------------------------
module microcode_sequencer #(
  parameter int BUS_SIZE = 8,
  parameter int ADR_SIZE = 4,
  parameter int STEPS    = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [BUS_SIZE-1:0] bus,
  input  logic                cf,
  input  logic                zf,
  output logic [BUS_SIZE-1:0] ir_out,
  output logic [2:0]          step,
  output logic                hlt,
  output logic                mi,
  output logic                ri,
  output logic                ro,
  output logic                io,
  output logic                ii,
  output logic                ai,
  output logic                ao,
  output logic                eo,
  output logic                su,
  output logic                bi,
  output logic                oi,
  output logic                ce,
  output logic                co,
  output logic                j,
  output logic                fi
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  logic [BUS_SIZE-1:0] ir;
  logic [3:0]          opcode;
  logic                halted;
  logic [2:0]          step_next;
  logic                halted_next;

  assign opcode = ir[BUS_SIZE-1 -: 4];
  assign ir_out = {{(BUS_SIZE-ADR_SIZE){1'b0}}, ir[ADR_SIZE-1:0]};

  // IR latches on the rising edge, in the middle of T1 where ii is asserted.
  // Because ii is 0 while halted, the IR is naturally frozen during halt.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ir <= '0;
    end else if (ii) begin
      ir <= bus;
    end
  end

  // Step counter and halt flag live on the falling edge so the control word
  // never changes near the rising edge that consumes it.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      step   <= '0;
      halted <= 1'b0;
    end else begin
      step   <= step_next;
      halted <= halted_next;
    end
  end

  // hlt is only ever 1 at T2 of HLT or while already halted, so holding the
  // counter whenever hlt is high freezes it at step 2.
  always_comb begin
    step_next   = step;
    halted_next = halted;
    if (hlt) begin
      halted_next = 1'b1;
    end else if (step == LAST_STEP) begin
      step_next = '0;
    end else begin
      step_next = step + 3'd1;
    end
  end

  // Control word decode. Only one of ao/ro/co/eo/io is raised in any row,
  // so the bus always has a single driver.
  always_comb begin
    hlt = 1'b0;
    mi  = 1'b0;
    ri  = 1'b0;
    ro  = 1'b0;
    io  = 1'b0;
    ii  = 1'b0;
    ai  = 1'b0;
    ao  = 1'b0;
    eo  = 1'b0;
    su  = 1'b0;
    bi  = 1'b0;
    oi  = 1'b0;
    ce  = 1'b0;
    co  = 1'b0;
    j   = 1'b0;
    fi  = 1'b0;
    if (!clr) begin
      if (halted) begin
        hlt = 1'b1;
      end else begin
        case (step)
          3'd0: begin
            co = 1'b1;
            mi = 1'b1;
          end
          3'd1: begin
            ro = 1'b1;
            ii = 1'b1;
            ce = 1'b1;
          end
          3'd2: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                io = 1'b1;
                mi = 1'b1;
              end
              OP_LDI: begin
                io = 1'b1;
                ai = 1'b1;
              end
              OP_JMP: begin
                io = 1'b1;
                j  = 1'b1;
              end
              // Flags are read combinationally, so j follows cf/zf within T2.
              OP_JC: begin
                io = 1'b1;
                j  = cf;
              end
              OP_JZ: begin
                io = 1'b1;
                j  = zf;
              end
              OP_OUT: begin
                ao = 1'b1;
                oi = 1'b1;
              end
              OP_HLT: begin
                hlt = 1'b1;
              end
              default: ;
            endcase
          end
          3'd3: begin
            case (opcode)
              OP_LDA: begin
                ro = 1'b1;
                ai = 1'b1;
              end
              OP_ADD, OP_SUB: begin
                ro = 1'b1;
                bi = 1'b1;
              end
              OP_STA: begin
                ao = 1'b1;
                ri = 1'b1;
              end
              default: ;
            endcase
          end
          3'd4: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
              eo = 1'b1;
              ai = 1'b1;
              fi = 1'b1;
              su = (opcode == OP_SUB);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_microcode_sequencer
//
// Table-driven bench for microcode_sequencer. Each table row is one
// instruction with its expected T2..T4 control words; the expected step,
// control word and ir_out for every sample are queued when the row is driven
// and popped as the DUT steps through the instruction. Hand-written sequences
// cover reset mid-instruction, flag changes inside T2 and halt.
// -----------------------------------------------------------------------------
module tb_microcode_sequencer;

  // Control word packing: {hlt,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi}
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [15:0] FETCH0 = C_CO | C_MI;
  localparam logic [15:0] FETCH1 = C_RO | C_II | C_CE;

  typedef struct {
    logic [7:0]  instr;
    logic        cf;
    logic        zf;
    logic [15:0] t2;
    logic [15:0] t3;
    logic [15:0] t4;
  } vec_t;

  typedef struct {
    logic [2:0]  step;
    logic [15:0] ctrl;
    logic [7:0]  ir;
  } exp_t;

  logic       clk;
  logic       clr;
  logic [7:0] bus;
  logic       cf;
  logic       zf;
  logic [7:0] ir_out;
  logic [2:0] step;
  logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
  logic [15:0] ctrl;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  assign ctrl = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

  microcode_sequencer #(
    .BUS_SIZE(8),
    .ADR_SIZE(4),
    .STEPS(5)
  ) dut (
    .clk(clk), .clr(clr), .bus(bus), .cf(cf), .zf(zf),
    .ir_out(ir_out), .step(step),
    .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
    .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Queue the full expected trace of one instruction: T0..T4 plus the
  // wrap back to T0 (IR retained).
  task automatic applyStimulus(input vec_t v);
    logic [7:0] opnd;
    opnd = {4'h0, v.instr[3:0]};
    bus = v.instr;
    cf  = v.cf;
    zf  = v.zf;
    exp_q.push_back('{3'd0, FETCH0, 8'h00});
    exp_q.push_back('{3'd1, FETCH1, 8'h00});
    exp_q.push_back('{3'd2, v.t2,   opnd});
    exp_q.push_back('{3'd3, v.t3,   opnd});
    exp_q.push_back('{3'd4, v.t4,   opnd});
    exp_q.push_back('{3'd0, FETCH0, opnd});
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    int drivers;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    if (step !== e.step || ctrl !== e.ctrl || ir_out !== e.ir) begin
      errors++;
      $display("[TB] FAIL %s: got step=%0d ctrl=0x%04h ir=0x%02h, expected step=%0d ctrl=0x%04h ir=0x%02h",
               name, step, ctrl, ir_out, e.step, e.ctrl, e.ir);
    end
    drivers = int'(ao) + int'(ro) + int'(co) + int'(eo) + int'(io);
    checks++;
    if (drivers > 1) begin
      errors++;
      $display("[TB] FAIL %s bus drivers: got %0d, expected at most 1", name, drivers);
    end
  endtask

  // Pulse clr across one rising edge and check the forced-zero state while it
  // is held; release lands 4 time units before the next falling edge.
  task automatic doReset(input string name);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    compare({name, " reset ctrl"}, {16'h0, ctrl}, 32'h0);
    compare({name, " reset step"}, {29'h0, step}, 32'h0);
    compare({name, " reset ir"},   {24'h0, ir_out}, 32'h0);
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
  endtask

  task automatic toNextStep();
    @(negedge clk);
    #2;
  endtask

  initial begin
    clr = 1'b1;
    bus = 8'h00;
    cf  = 1'b0;
    zf  = 1'b0;

    // Every opcode 0..F except HLT, plus both flag outcomes for JC/JZ.
    vecs.push_back('{8'h00, 1'b0, 1'b0, 16'h0,         16'h0,         16'h0});
    vecs.push_back('{8'h1E, 1'b0, 1'b0, C_IO | C_MI,   C_RO | C_AI,   16'h0});
    vecs.push_back('{8'h2A, 1'b0, 1'b0, C_IO | C_MI,   C_RO | C_BI,   C_EO | C_AI | C_FI});
    vecs.push_back('{8'h3C, 1'b1, 1'b1, C_IO | C_MI,   C_RO | C_BI,   C_EO | C_AI | C_FI | C_SU});
    vecs.push_back('{8'h47, 1'b0, 1'b0, C_IO | C_MI,   C_AO | C_RI,   16'h0});
    vecs.push_back('{8'h53, 1'b0, 1'b0, C_IO | C_AI,   16'h0,         16'h0});
    vecs.push_back('{8'h6F, 1'b0, 1'b0, C_IO | C_J,    16'h0,         16'h0});
    vecs.push_back('{8'h75, 1'b0, 1'b1, C_IO,          16'h0,         16'h0});
    vecs.push_back('{8'h75, 1'b1, 1'b0, C_IO | C_J,    16'h0,         16'h0});
    vecs.push_back('{8'h85, 1'b1, 1'b0, C_IO,          16'h0,         16'h0});
    vecs.push_back('{8'h85, 1'b0, 1'b1, C_IO | C_J,    16'h0,         16'h0});
    vecs.push_back('{8'h91, 1'b1, 1'b1, 16'h0,         16'h0,         16'h0});
    vecs.push_back('{8'hA2, 1'b1, 1'b1, 16'h0,         16'h0,         16'h0});
    vecs.push_back('{8'hB3, 1'b1, 1'b1, 16'h0,         16'h0,         16'h0});
    vecs.push_back('{8'hC4, 1'b1, 1'b1, 16'h0,         16'h0,         16'h0});
    vecs.push_back('{8'hD5, 1'b1, 1'b1, 16'h0,         16'h0,         16'h0});
    vecs.push_back('{8'hE9, 1'b0, 1'b0, C_AO | C_OI,   16'h0,         16'h0});

    #1;
    compare("power-on ctrl", {16'h0, ctrl}, 32'h0);
    compare("power-on step", {29'h0, step}, 32'h0);

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("instr 0x%02h cf=%0d zf=%0d", vecs[i].instr, vecs[i].cf, vecs[i].zf);
      applyStimulus(vecs[i]);
      doReset(nm);
      checkOutput({nm, " T0"});
      for (int s = 1; s <= 5; s++) begin
        toNextStep();
        checkOutput($sformatf("%s T%0d", nm, s % 5));
      end
    end

    // Reset in the middle of an ADD: immediate abort, then a clean restart.
    bus = 8'h2A;
    doReset("abort");
    repeat (3) toNextStep();
    compare("abort pre step", {29'h0, step}, 32'd3);
    compare("abort pre ctrl", {16'h0, ctrl}, {16'h0, C_RO | C_BI});
    #1 clr = 1'b1;
    #1;
    compare("abort step", {29'h0, step}, 32'd0);
    compare("abort ctrl", {16'h0, ctrl}, 32'h0);
    compare("abort ir",   {24'h0, ir_out}, 32'h0);
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    compare("abort release T0", {16'h0, ctrl}, {16'h0, FETCH0});
    toNextStep();
    compare("abort release step", {29'h0, step}, 32'd1);
    compare("abort release T1", {16'h0, ctrl}, {16'h0, FETCH1});

    // Flags are combinational during T2: j tracks cf/zf mid-step.
    bus = 8'h75;
    cf  = 1'b0;
    zf  = 1'b0;
    doReset("jc flag");
    repeat (2) toNextStep();
    compare("jc cf=0", {16'h0, ctrl}, {16'h0, C_IO});
    cf = 1'b1;
    #1;
    compare("jc cf rise", {16'h0, ctrl}, {16'h0, C_IO | C_J});
    cf = 1'b0;
    #1;
    compare("jc cf fall", {16'h0, ctrl}, {16'h0, C_IO});

    bus = 8'h85;
    doReset("jz flag");
    repeat (2) toNextStep();
    compare("jz zf=0", {16'h0, ctrl}, {16'h0, C_IO});
    zf = 1'b1;
    #1;
    compare("jz zf rise", {16'h0, ctrl}, {16'h0, C_IO | C_J});
    zf = 1'b0;

    // Halt: step freezes at 2, only hlt stays up, IR ignores the bus.
    bus = 8'hF0;
    doReset("halt");
    repeat (2) toNextStep();
    compare("halt T2 ctrl", {16'h0, ctrl}, {16'h0, C_HLT});
    compare("halt T2 step", {29'h0, step}, 32'd2);
    bus = 8'h1E;
    for (int k = 0; k < 10; k++) begin
      toNextStep();
      compare($sformatf("halted step c%0d", k), {29'h0, step}, 32'd2);
      compare($sformatf("halted ctrl c%0d", k), {16'h0, ctrl}, {16'h0, C_HLT});
      compare($sformatf("halted ir c%0d", k),   {24'h0, ir_out}, 32'h0);
    end
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    compare("halt clr ctrl", {16'h0, ctrl}, 32'h0);
    compare("halt clr step", {29'h0, step}, 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    compare("halt exit T0", {16'h0, ctrl}, {16'h0, FETCH0});
    toNextStep();
    compare("halt exit step", {29'h0, step}, 32'd1);

    compare("scoreboard drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
